// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU issue sequencer. Holds the ALU
//               operation codes (shared with the ALU), the RV32I major opcodes,
//               the FSM state encodings and the immediate sign-extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // ALU operation codes, bit-exact with the ALU's decoder
    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SLL    = 5'b00101;
    localparam logic [4:0] ALU_SRL    = 5'b00110;
    localparam logic [4:0] ALU_SLT    = 5'b00111;
    localparam logic [4:0] ALU_SRA    = 5'b01110;
    localparam logic [4:0] ALU_SLTU   = 5'b01111;
    localparam logic [4:0] ALU_SLL_12 = 5'b10000;
    localparam logic [4:0] ALU_SLL_I  = 5'b10001;
    localparam logic [4:0] ALU_SRL_I  = 5'b10010;
    localparam logic [4:0] ALU_SRA_I  = 5'b10011;

    // RV32I major opcodes handled by this block
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values that select the alternate (SUB / SRA) operations
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXEC    = 2'd1;
    localparam logic [1:0] ST_CAPT    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Sign-extend a 12-bit I-type immediate to 32 bits
    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decode.sv
// ============================================================================
// Module      : alu_decode
// Description : Combinational RV32I decoder. Maps instr/pc/rs1/rs2 onto the
//               ALU control code, operand A/B, destination register and an
//               illegal flag. Illegal encodings collapse to ADD 0,0 with rd=0
//               so they complete as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    output logic [4:0]      ctr_o,
    output logic [XLEN-1:0] src_a_o,
    output logic [XLEN-1:0] src_b_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_shamt;

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];
    assign w_shamt  = {{(XLEN-SHAMT_W){1'b0}}, instr_i[20 +: SHAMT_W]};

    // Decode the instruction fields into ALU control and operands
    always_comb begin
        ctr_o     = ALU_ADD;
        src_a_o   = '0;
        src_b_o   = '0;
        rd_o      = instr_i[11:7];
        illegal_o = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                src_a_o = rs1_val_i;
                src_b_o = rs2_val_i;
                case (w_f3)
                    3'b000: begin
                        if (w_f7 == F7_BASE)     ctr_o = ALU_ADD;
                        else if (w_f7 == F7_ALT) ctr_o = ALU_SUB;
                        else                     illegal_o = 1'b1;
                    end
                    3'b101: begin
                        if (w_f7 == F7_BASE)     ctr_o = ALU_SRL;
                        else if (w_f7 == F7_ALT) ctr_o = ALU_SRA;
                        else                     illegal_o = 1'b1;
                    end
                    default: begin
                        // Only the base funct7 is valid for the remaining ops
                        if (w_f7 != F7_BASE) illegal_o = 1'b1;
                        case (w_f3)
                            3'b001:  ctr_o = ALU_SLL;
                            3'b010:  ctr_o = ALU_SLT;
                            3'b011:  ctr_o = ALU_SLTU;
                            3'b100:  ctr_o = ALU_XOR;
                            3'b110:  ctr_o = ALU_OR;
                            default: ctr_o = ALU_AND;
                        endcase
                    end
                endcase
            end
            OPC_OP_IMM: begin
                src_a_o = rs1_val_i;
                src_b_o = sext12(instr_i[31:20]);
                case (w_f3)
                    3'b000: ctr_o = ALU_ADD;
                    3'b010: ctr_o = ALU_SLT;
                    3'b011: ctr_o = ALU_SLTU;
                    3'b100: ctr_o = ALU_XOR;
                    3'b110: ctr_o = ALU_OR;
                    3'b111: ctr_o = ALU_AND;
                    3'b001: begin
                        src_b_o = w_shamt;
                        ctr_o   = ALU_SLL_I;
                        if (w_f7 != F7_BASE) illegal_o = 1'b1;
                    end
                    default: begin
                        // f3=101: instr[30] selects arithmetic right shift
                        src_b_o = w_shamt;
                        if (w_f7 == F7_BASE)     ctr_o = ALU_SRL_I;
                        else if (w_f7 == F7_ALT) ctr_o = ALU_SRA_I;
                        else                     illegal_o = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                // ALU shifts the 20-bit immediate into the upper bits
                ctr_o   = ALU_SLL_12;
                src_a_o = {{(XLEN-20){1'b0}}, instr_i[31:12]};
                src_b_o = '0;
            end
            OPC_AUIPC: begin
                ctr_o   = ALU_ADD;
                src_a_o = pc_i;
                src_b_o = {instr_i[31:12], 12'b0};
            end
            default: illegal_o = 1'b1;
        endcase

        // Illegal encodings become a harmless NOP: ADD 0,0 with no writeback
        if (illegal_o) begin
            ctr_o   = ALU_ADD;
            src_a_o = '0;
            src_b_o = '0;
            rd_o    = 5'd0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_seq.sv
// ============================================================================
// Module      : alu_issue_seq
// Description : Issue/sequencer side of the ALU interface. Accepts one
//               instruction in IDLE, drives registered control/operands to
//               the ALU, waits the ALU's one-cycle latency, captures the
//               result and hands it out with rd on a valid/ready port.
//               Optional macro ALU_ISSUE_ILLEGAL_EN adds the out_illegal port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic [4:0]      ALU_ctr,
    output logic [XLEN-1:0] ALU_srcA,
    output logic [XLEN-1:0] ALU_srcB,
    input  logic [XLEN-1:0] ALU_resp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
`ifdef ALU_ISSUE_ILLEGAL_EN
    output logic            out_illegal,
`endif
    output logic [4:0]      out_rd
);

    logic [4:0]      dec_ctr;
    logic [XLEN-1:0] dec_src_a;
    logic [XLEN-1:0] dec_src_b;
    logic [4:0]      dec_rd;
    logic            dec_illegal;

    alu_decode #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_decode (
        .instr_i   (in_instr),
        .pc_i      (in_pc),
        .rs1_val_i (in_rs1_val),
        .rs2_val_i (in_rs2_val),
        .ctr_o     (dec_ctr),
        .src_a_o   (dec_src_a),
        .src_b_o   (dec_src_b),
        .rd_o      (dec_rd),
        .illegal_o (dec_illegal)
    );

    logic [1:0]      state_q,    state_d;
    logic            in_ready_q, in_ready_d;
    logic [4:0]      ctr_q,      ctr_d;
    logic [XLEN-1:0] src_a_q,    src_a_d;
    logic [XLEN-1:0] src_b_q,    src_b_d;
    logic [4:0]      rd_q,       rd_d;
    logic [XLEN-1:0] result_q,   result_d;
    logic            valid_q,    valid_d;
    logic            accept;

    assign accept = (state_q == ST_IDLE) && in_valid && in_ready_q;

    // Next-state and datapath-register update for the issue FSM
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        rd_d     = rd_q;
        result_d = result_q;
        valid_d  = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ctr_d   = dec_ctr;
                    src_a_d = dec_src_a;
                    src_b_d = dec_src_b;
                    rd_d    = dec_rd;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_CAPT;
            ST_CAPT: begin
                result_d = ALU_resp;
                valid_d  = 1'b1;
                state_d  = ST_DONE;
            end
            default: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Ready is a registered copy of "next state is IDLE", so it rises one
        // edge after reset release and one edge after the result handshake
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops any in-flight instruction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            ctr_q      <= ALU_ADD;
            src_a_q    <= '0;
            src_b_q    <= '0;
            rd_q       <= 5'd0;
            result_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            ctr_q      <= ctr_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic ill_pend_q;
    logic ill_q;

    // Carry the illegal flag from accept to capture, then present it with the result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ill_pend_q <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            if (accept)
                ill_pend_q <= dec_illegal;
            if (state_q == ST_CAPT)
                ill_q <= ill_pend_q;
            else if (state_q == ST_DONE && out_ready)
                ill_q <= 1'b0;
        end
    end

    assign out_illegal = ill_q;
`else
    // Decoder already turns illegal encodings into a NOP; the flag itself is not exported
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

    assign in_ready   = in_ready_q;
    assign ALU_ctr    = ctr_q;
    assign ALU_srcA   = src_a_q;
    assign ALU_srcB   = src_b_q;
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_rd     = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
// ============================================================================
// Module      : tb_alu_issue_seq
// Description : Directed self-checking bench for alu_issue_seq. Includes a
//               registered ALU model driving ALU_resp one clock after
//               ALU_ctr/srcA/srcB. Honors ALU_ISSUE_ILLEGAL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [4:0]  ALU_ctr;
    logic [31:0] ALU_srcA;
    logic [31:0] ALU_srcB;
    logic [31:0] ALU_resp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        out_illegal;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .ALU_ctr    (ALU_ctr),
        .ALU_srcA   (ALU_srcA),
        .ALU_srcB   (ALU_srcB),
        .ALU_resp   (ALU_resp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
`ifdef ALU_ISSUE_ILLEGAL_EN
        .out_illegal(out_illegal),
`endif
        .out_rd     (out_rd)
    );

    // External ALU: registered result one clock after control/operands
    function automatic logic [31:0] alu_f(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            5'b00000: return a + b;
            5'b00001: return a - b;
            5'b00010: return a & b;
            5'b00011: return a | b;
            5'b00100: return a ^ b;
            5'b00101, 5'b10001: return a << b[4:0];
            5'b00110, 5'b10010: return a >> b[4:0];
            5'b00111: return {31'b0, $signed(a) < $signed(b)};
            5'b01110, 5'b10011: return $unsigned($signed(a) >>> b[4:0]);
            5'b01111: return {31'b0, a < b};
            5'b10000: return a << 12;
            default:  return 32'h0;
        endcase
    endfunction

    always @(posedge clk) ALU_resp <= alu_f(ALU_ctr, ALU_srcA, ALU_srcB);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present one instruction for exactly one edge
    task automatic do_accept(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] rs2);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%b required 1 within 20 cycles", in_ready);
        end
        in_instr   = instr;
        in_pc      = pc;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (ALU_ctr !== 5'b00000)   begin errors++; $display("FAIL rst_ctr: got %b exp 00000", ALU_ctr); end
        checks++; if ({ALU_srcA, ALU_srcB} !== 64'h0) begin errors++; $display("FAIL rst_src: got %h %h exp 0 0", ALU_srcA, ALU_srcB); end
        checks++; if (out_result !== 32'h0 || out_rd !== 5'd0) begin errors++; $display("FAIL rst_out: got %h rd %0d exp 0 rd 0", out_result, out_rd); end
`ifdef ALU_ISSUE_ILLEGAL_EN
        checks++; if (out_illegal !== 1'b0)   begin errors++; $display("FAIL rst_illegal: got %b exp 0", out_illegal); end
`endif
        resetn = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL rst_release_ready: got %b exp 0 before edge", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL rst_ready_rise: got %b exp 1", in_ready); end
    endtask

    // ADD x3,x1,x2 with full timing of the handshake
    task automatic test_add();
        do_accept(32'h002081B3, 32'h0, 32'd5, 32'd7);
        checks++; if (ALU_ctr !== 5'b00000) begin errors++; $display("FAIL add_ctr: got %b exp 00000", ALU_ctr); end
        checks++; if (ALU_srcA !== 32'd5 || ALU_srcB !== 32'd7) begin errors++; $display("FAIL add_src: got %h %h exp 5 7", ALU_srcA, ALU_srcB); end
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL add_busy: in_ready=%b exp 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL add_early_valid: got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL add_valid: got %b exp 1", out_valid); end
        checks++; if (out_result !== 32'd12) begin errors++; $display("FAIL add_result: got %h exp 0000000c", out_result); end
        checks++; if (out_rd !== 5'd3)      begin errors++; $display("FAIL add_rd: got %0d exp 3", out_rd); end
`ifdef ALU_ISSUE_ILLEGAL_EN
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal: got %b exp 0", out_illegal); end
`endif
        handshake();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_release: valid=%b ready=%b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_sub();
        do_accept(32'h40208233, 32'h0, 32'd3, 32'd5);
        checks++; if (ALU_ctr !== 5'b00001) begin errors++; $display("FAIL sub_ctr: got %b exp 00001", ALU_ctr); end
        tick(); tick();
        checks++; if (out_result !== 32'hFFFFFFFE || out_rd !== 5'd4) begin errors++; $display("FAIL sub_result: got %h rd %0d exp fffffffe rd 4", out_result, out_rd); end
        handshake();
    endtask

    task automatic test_srai();
        do_accept(32'h4040D293, 32'h0, 32'h80000000, 32'h0);
        checks++; if (ALU_ctr !== 5'b10011 || ALU_srcB !== 32'd4) begin errors++; $display("FAIL srai_ctl: got ctr %b srcB %h exp 10011 4", ALU_ctr, ALU_srcB); end
        tick(); tick();
        checks++; if (out_result !== 32'hF8000000 || out_rd !== 5'd5) begin errors++; $display("FAIL srai_result: got %h rd %0d exp f8000000 rd 5", out_result, out_rd); end
        handshake();
    endtask

    // ADDI x9,x1,-1: immediate sign extension to all ones
    task automatic test_addi_neg();
        do_accept(32'hFFF08493, 32'h0, 32'h0, 32'h12345678);
        checks++; if (ALU_srcB !== 32'hFFFFFFFF || ALU_srcA !== 32'h0) begin errors++; $display("FAIL addi_src: got %h %h exp 0 ffffffff", ALU_srcA, ALU_srcB); end
        tick(); tick();
        checks++; if (out_result !== 32'hFFFFFFFF || out_rd !== 5'd9) begin errors++; $display("FAIL addi_result: got %h rd %0d exp ffffffff rd 9", out_result, out_rd); end
        handshake();
    endtask

    task automatic test_lui_auipc();
        do_accept(32'h12345337, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        checks++; if (ALU_ctr !== 5'b10000 || ALU_srcA !== 32'h00012345 || ALU_srcB !== 32'h0) begin errors++; $display("FAIL lui_ctl: got %b %h %h exp 10000 00012345 0", ALU_ctr, ALU_srcA, ALU_srcB); end
        tick(); tick();
        checks++; if (out_result !== 32'h12345000 || out_rd !== 5'd6) begin errors++; $display("FAIL lui_result: got %h rd %0d exp 12345000 rd 6", out_result, out_rd); end
        handshake();
        do_accept(32'h00001397, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        checks++; if (ALU_ctr !== 5'b00000 || ALU_srcA !== 32'h100 || ALU_srcB !== 32'h1000) begin errors++; $display("FAIL auipc_ctl: got %b %h %h exp 00000 100 1000", ALU_ctr, ALU_srcA, ALU_srcB); end
        tick(); tick();
        checks++; if (out_result !== 32'h1100 || out_rd !== 5'd7) begin errors++; $display("FAIL auipc_result: got %h rd %0d exp 1100 rd 7", out_result, out_rd); end
        handshake();
    endtask

    // ADD x0,x1,x2: rd=0 passes through, result still computed
    task automatic test_rd_zero();
        do_accept(32'h00208033, 32'h0, 32'd5, 32'd7);
        tick(); tick();
        checks++; if (out_result !== 32'd12 || out_rd !== 5'd0) begin errors++; $display("FAIL rd0: got %h rd %0d exp c rd 0", out_result, out_rd); end
        handshake();
    endtask

    // Consumer stalls 5 cycles; a second instruction offered meanwhile is ignored
    task automatic test_back_pressure();
        do_accept(32'h002081B3, 32'h0, 32'd5, 32'd7);
        tick(); tick();
        in_instr   = 32'h40208233;
        in_rs1_val = 32'd100;
        in_rs2_val = 32'd1;
        in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'd12 || out_rd !== 5'd3 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b result=%h rd=%0d ready=%b exp 1 c 3 0", i, out_valid, out_result, out_rd, in_ready);
            end
            tick();
        end
        checks++; if (ALU_ctr !== 5'b00000 || ALU_srcA !== 32'd5) begin errors++; $display("FAIL hold_ignored: ctr=%b srcA=%h exp 00000 5", ALU_ctr, ALU_srcA); end
        in_valid = 1'b0;
        handshake();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: valid=%b ready=%b exp 0 1", out_valid, in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL hold_no_extra: ready=%b valid=%b exp 1 0", in_ready, out_valid); end
    endtask

    // Reset pulsed while the instruction is in EXEC
    task automatic test_reset_mid();
        do_accept(32'h002081B3, 32'h0, 32'd5, 32'd7);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: valid=%b ready=%b exp 0 0", out_valid, in_ready); end
        checks++; if (ALU_ctr !== 5'b0 || ALU_srcA !== 32'h0 || ALU_srcB !== 32'h0 || out_rd !== 5'd0) begin errors++; $display("FAIL mid_rst_regs: ctr=%b A=%h B=%h rd=%0d exp 0", ALU_ctr, ALU_srcA, ALU_srcB, out_rd); end
        tick();
        resetn = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready0: got %b exp 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready1: got %b exp 1", in_ready); end
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || out_result !== 32'h0) begin errors++; $display("FAIL mid_rst_dropped: valid=%b result=%h exp 0 0", out_valid, out_result); end
    endtask

    // LW x8 (unsupported opcode) and an R-type with bad funct7 become NOPs
    task automatic test_illegal();
        do_accept(32'h00012403, 32'h0, 32'd5, 32'd7);
        checks++; if (ALU_ctr !== 5'b0 || ALU_srcA !== 32'h0 || ALU_srcB !== 32'h0) begin errors++; $display("FAIL ill_ctl: got %b %h %h exp 0 0 0", ALU_ctr, ALU_srcA, ALU_srcB); end
        tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h0 || out_rd !== 5'd0) begin errors++; $display("FAIL ill_result: valid=%b result=%h rd=%0d exp 1 0 0", out_valid, out_result, out_rd); end
`ifdef ALU_ISSUE_ILLEGAL_EN
        checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b exp 1", out_illegal); end
`endif
        handshake();
        do_accept(32'h02208233, 32'h0, 32'd5, 32'd7);
        tick(); tick();
        checks++; if (out_result !== 32'h0 || out_rd !== 5'd0) begin errors++; $display("FAIL ill_f7: result=%h rd=%0d exp 0 0", out_result, out_rd); end
        handshake();
    endtask

    initial begin
        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_instr   = 32'h0;
        in_pc      = 32'h0;
        in_rs1_val = 32'h0;
        in_rs2_val = 32'h0;
        out_ready  = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_srai();
        test_addi_neg();
        test_lui_auipc();
        test_rd_zero();
        test_back_pressure();
        test_reset_mid();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
